// File: rtl/ex_muldiv_seq_pkg.sv
// ex_muldiv_seq_pkg: shared encodings for the RV32M multiply/divide sequencer.
package ex_muldiv_seq_pkg;
    localparam logic [6:0] M_FUNCT7 = 7'b0000001;
    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;
    function automatic logic rs1_signed(input logic [2:0] f);
        return f inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction
    function automatic logic rs2_signed(input logic [2:0] f);
        return f inside {F3_MULH, F3_DIV, F3_REM};
    endfunction
endpackage

// File: rtl/ex_muldiv_seq_signfix.sv
// ex_muldiv_signfix: conditional two's-complement negate, used for operand
// magnitudes at issue and for result sign correction.
module ex_muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);
    assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide sequencer for the EX stage.
// Define MULDIV_EARLY_OUT_EN to short-circuit zero multiplies and small-dividend divides.
module ex_muldiv_seq
    import ex_muldiv_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    state_e              r_state, w_next;
    logic [2:0]          r_f3;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_prod;
    logic [XLEN-1:0]     r_b;
    logic                r_neg_q, r_neg_r;
    logic                w_neg_a, w_neg_b, w_div, w_dz, w_ovf, w_early, w_short, w_accept, w_ge;
    logic [XLEN-1:0]     w_abs_a, w_abs_b, w_diff, w_q_fix, w_r_fix, w_result;
    logic [XLEN:0]       w_acc, w_rem;
    logic [2*XLEN-1:0]   w_short_prod, w_calc, w_prod_fix;

    assign w_neg_a  = rs1_signed(funct3_i) & rs1_i[XLEN-1];
    assign w_neg_b  = rs2_signed(funct3_i) & rs2_i[XLEN-1];
    assign w_div    = funct3_i[2];
    assign w_dz     = w_div && rs2_i == '0;
    assign w_ovf    = w_div && !funct3_i[0] && rs1_i == {1'b1, {(XLEN-1){1'b0}}} && rs2_i == '1;
`ifdef MULDIV_EARLY_OUT_EN
    assign w_early  = w_div ? (w_abs_a < w_abs_b) : (rs1_i == '0 || rs2_i == '0);
`else
    assign w_early  = 1'b0;
`endif
    assign w_short  = w_dz | w_ovf | w_early;
    assign w_accept = r_state == S_IDLE && start_i && !flush_i;

    // Short paths preload {remainder, quotient} (or a zero product) so FIX passes it through unsigned.
    assign w_short_prod = !w_div ? '0 :
                          w_dz   ? {rs1_i, {XLEN{1'b1}}} :
                          w_ovf  ? {{XLEN{1'b0}}, rs1_i} :
                                   {rs1_i, {XLEN{1'b0}}};

    ex_muldiv_signfix #(.W(XLEN)) u_abs_a (.i_val(rs1_i), .i_neg(w_neg_a), .o_val(w_abs_a));
    ex_muldiv_signfix #(.W(XLEN)) u_abs_b (.i_val(rs2_i), .i_neg(w_neg_b), .o_val(w_abs_b));

    // Multiply: high half accumulates, low half holds the shrinking multiplier.
    // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
    assign w_acc  = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_b} : '0);
    assign w_rem  = r_prod[2*XLEN-1:XLEN-1];
    assign w_ge   = w_rem[XLEN] || w_rem[XLEN-1:0] >= r_b;
    assign w_diff = w_rem[XLEN-1:0] - r_b;
    assign w_calc = !r_f3[2] ? {w_acc, r_prod[XLEN-1:1]} :
                    w_ge     ? {w_diff, r_prod[XLEN-2:0], 1'b1} :
                               {w_rem[XLEN-1:0], r_prod[XLEN-2:0], 1'b0};

    ex_muldiv_signfix #(.W(2*XLEN)) u_fix_p (.i_val(r_prod), .i_neg(r_neg_q), .o_val(w_prod_fix));
    ex_muldiv_signfix #(.W(XLEN)) u_fix_q (.i_val(r_prod[XLEN-1:0]), .i_neg(r_neg_q), .o_val(w_q_fix));
    ex_muldiv_signfix #(.W(XLEN)) u_fix_r (.i_val(r_prod[2*XLEN-1:XLEN]), .i_neg(r_neg_r), .o_val(w_r_fix));

    assign w_result = r_f3 == F3_MUL ? w_prod_fix[XLEN-1:0] :
                      !r_f3[2]       ? w_prod_fix[2*XLEN-1:XLEN] :
                      r_f3[1]        ? w_r_fix : w_q_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush_i) w_next = S_IDLE;
        else case (r_state)
            S_IDLE:  if (start_i) w_next = w_short ? S_FIX : S_CALC;
            S_CALC:  if (r_cnt == CNT_W'(XLEN-1)) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = r_state != S_IDLE;
        done_o = r_state == S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f3     <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_b      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            result_o <= '0;
        end else if (w_accept) begin
            r_f3    <= funct3_i;
            r_cnt   <= '0;
            r_b     <= w_abs_b;
            r_prod  <= w_short ? w_short_prod : {{XLEN{1'b0}}, w_abs_a};
            r_neg_q <= !w_short && (w_neg_a ^ w_neg_b);
            r_neg_r <= !w_short && w_neg_a;
        end else if (r_state == S_CALC) begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_prod <= w_calc;
        end else if (r_state == S_FIX && !flush_i) begin
            result_o <= w_result;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb_ex_muldiv_seq: scoreboard bench for ex_muldiv_seq against an arithmetic reference model.
module tb_ex_muldiv_seq;
    localparam int XLEN = 32;
    logic        clk = 1'b0, rst_n = 1'b1, start_i = 1'b0, flush_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] rs1_i = '0, rs2_i = '0;
    logic        busy_o, done_o;
    logic [31:0] result_o;
    int n_chk = 0, n_fail = 0, edge_n = 0;

    typedef struct {
        logic [31:0] res;
        int          at;
        logic [2:0]  f;
        logic [31:0] a, b;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    ex_muldiv_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .flush_i(flush_i),
        .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sa, sb2, ua, ub, p;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb2 = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (f)
            3'd0: begin p = sa * sb2; return p[31:0]; end
            3'd1: begin p = sa * sb2; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin p = sa / sb2; return b == 0 ? 32'hFFFF_FFFF : ovf ? a : p[31:0]; end
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: begin p = sa % sb2; return b == 0 ? a : ovf ? 32'h0 : p[31:0]; end
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic bit is_short(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic [31:0] ma, mb;
        bit s;
        s  = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        ma = (f[2] && !f[0] && a[31]) ? -a : a;
        mb = (f[2] && !f[0] && b[31]) ? -b : b;
`ifdef MULDIV_EARLY_OUT_EN
        s = s || (f[2] ? ma < mb : (a == 0 || b == 0));
`else
        s = s || (ma == 32'hFFFF_FFFF && mb == 32'hFFFF_FFFF && 1'b0);
`endif
        return s;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
    task automatic issue(logic [2:0] f, logic [31:0] a, logic [31:0] b, logic [31:0] exp_res, bit push);
        int t;
        funct3_i = f; rs1_i = a; rs2_i = b; start_i = 1'b1;
        t = edge_n + 1;
        if (push) sb.push_back('{exp_res, t + (is_short(f, a, b) ? 1 : XLEN + 1), f, a, b});
        @(negedge clk);
        start_i = 1'b0;
        check("busy_after_start", {31'b0, busy_o}, 32'd1);
    endtask

    task automatic wait_done();
        int k = 0;
        bit gap = 0;
        while (!done_o && k < 60) begin
            if (!busy_o) gap = 1;
            @(negedge clk);
            k++;
        end
        if (k >= 60) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: no done_o within %0d cycles", k);
        end
        check("busy_held", {31'b0, gap}, 32'd0);
        @(negedge clk);
        check("busy_release", {31'b0, busy_o}, 32'd0);
    endtask

    task automatic run(logic [2:0] f, logic [31:0] a, logic [31:0] b, logic [31:0] exp_res);
        issue(f, a, b, exp_res, 1'b1);
        wait_done();
    endtask

    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_done: result %h with nothing outstanding", result_o);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("result f3=%0d a=%h b=%h", mon_e.f, mon_e.a, mon_e.b), result_o, mon_e.res);
                check("done_cycle", edge_n, mon_e.at);
                check("busy_in_done", {31'b0, busy_o}, 32'd1);
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_busy", {31'b0, busy_o}, 32'd0);
        check("reset_done", {31'b0, done_o}, 32'd0);
        check("reset_result", result_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(3'd0, 32'd7, 32'd6, 32'd42);
        run(3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run(3'd3, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
        run(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run(3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF);
        run(3'd7, 32'd100, 32'd0, 32'd100);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run(3'd5, 32'd3, 32'd10, 32'h0);
        run(3'd0, 32'd0, 32'd12345, 32'h0);
        run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

        // Flush mid-multiply: accepted at edge T, flush sampled at edge T+10.
        issue(3'd0, 32'd3, 32'd5, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_busy", {31'b0, busy_o}, 32'd0);
        check("flush_result_kept", result_o, 32'h8000_0000);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        wait_done();

        // Asynchronous reset while calculating.
        issue(3'd0, 32'd1234, 32'd5678, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'b0, busy_o}, 32'd0);
        check("async_rst_done", {31'b0, done_o}, 32'd0);
        check("async_rst_result", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            int mode;
            f    = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 9);
            a    = $urandom;
            b    = $urandom;
            if (mode == 0) b = 32'd0;
            else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (mode == 2) begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(0, 50)); end
            else if (mode == 3) b = 32'($urandom_range(1, 9)) ^ {32{b[31]}};
            run(f, a, b, ref_model(f, a, b));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
